// File: rtl/mhp_pkg.sv
// Shared constants for the Ethernet TX arbiter: FSM state encodings, default
// frame timing parameters and a small owner-to-one-hot helper.
package mhp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam int DEF_IFG_CYCLES = 12;
    localparam int DEF_MAX_LEN    = 1518;
    localparam int DEF_LEN_W      = 11;

    // Owner is a single bit: 0 = requester 0, 1 = requester 1.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: a lone requester wins outright, a tie goes to
// the requester that did not win last time (last_grant: 1 = req1 won last).
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-level arbiter muxing two byte-stream requesters onto one Ethernet write
// channel, with oversize-frame abort/drain and an enforced inter-frame gap.
module eth_tx_arbiter
    import mhp_pkg::*;
#(
    parameter int IFG_CYCLES = DEF_IFG_CYCLES,
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_req0_data,
    input  logic       i_req0_valid,
    input  logic       i_req0_last,
    output logic       o_req0_ready,
    input  logic [7:0] i_req1_data,
    input  logic       i_req1_valid,
    input  logic       i_req1_last,
    output logic       o_req1_ready,
    output logic [7:0] o_wdata,
    output logic       o_wvalid,
    input  logic       i_wready,
    output logic [1:0] o_grant,
    output logic       o_busy,
    output logic       o_err
);

    localparam int                GAP_W     = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
    localparam logic [LEN_W-1:0]  LEN_LIMIT = LEN_W'(MAX_LEN);
    localparam logic [1:0]        END_STATE = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;

    logic [1:0]       state_reg, state_next;
    logic             owner_reg, owner_next;
    logic             last_grant_reg, last_grant_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic             err_reg, err_next;

    logic [1:0] req_valid;
    logic [1:0] req_last;
    logic [7:0] req_data [2];
    logic [1:0] req_ready;
    logic [1:0] arb_grant;
    logic       own_valid;
    logic       own_last;
    logic       in_busy;
    logic       in_drain;
    logic       beat;

    assign req_valid   = {i_req1_valid, i_req0_valid};
    assign req_last    = {i_req1_last, i_req0_last};
    assign req_data[0] = i_req0_data;
    assign req_data[1] = i_req1_data;

    assign own_valid = req_valid[owner_reg];
    assign own_last  = req_last[owner_reg];
    assign in_busy   = (state_reg == ST_BUSY);
    assign in_drain  = (state_reg == ST_DRAIN);
    // In DRAIN the owner's ready is forced high, so a beat is just its valid.
    assign beat      = own_valid && ((in_busy && i_wready) || in_drain);

    rr_arb2 u_rr_arb2 (
        .req0       (i_req0_valid),
        .req1       (i_req1_valid),
        .last_grant (last_grant_reg),
        .grant      (arb_grant)
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign req_ready[gi] = (owner_reg == 1'(gi)) && ((in_busy && i_wready) || in_drain);
    end

    assign o_req0_ready = req_ready[0];
    assign o_req1_ready = req_ready[1];
    assign o_wvalid     = in_busy && own_valid;
    assign o_wdata      = in_busy ? req_data[owner_reg] : 8'h00;
    assign o_grant      = (in_busy || in_drain) ? owner_onehot(owner_reg) : 2'b00;
    assign o_busy       = (state_reg != ST_IDLE);
    assign o_err        = err_reg;

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        gap_next        = gap_reg;
        err_next        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|arb_grant) begin
                    owner_next = arb_grant[1];
                    cnt_next   = '0;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (beat) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (own_last) begin
                        last_grant_next = owner_reg;
                        gap_next        = '0;
                        state_next      = END_STATE;
                    end else if (cnt_next == LEN_LIMIT) begin
                        err_next   = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // An aborted frame still uses up the owner's round-robin turn.
                if (beat) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (own_last) begin
                        last_grant_next = owner_reg;
                        gap_next        = '0;
                        state_next      = END_STATE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            cnt_reg        <= '0;
            gap_reg        <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            gap_reg        <= gap_next;
            err_reg        <= err_next;
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: three instances (default, MAX_LEN=8,
// IFG_CYCLES=0) share stimulus; each scenario observes the relevant instance.
module tb_eth_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic       wready = 1'b0;

    logic [2:0] rdy0, rdy1, wvalid, busy, err_w;
    logic [7:0] wdata_w [3];
    logic [1:0] grant_w [3];

    int n_total = 0;
    int n_pass  = 0;

    localparam int IFG_P [3] = '{12, 12, 0};
    localparam int MAX_P [3] = '{1518, 8, 1518};
    localparam int LEN_P [3] = '{11, 4, 11};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        eth_tx_arbiter #(
            .IFG_CYCLES (IFG_P[gi]),
            .MAX_LEN    (MAX_P[gi]),
            .LEN_W      (LEN_P[gi])
        ) u_dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_req0_data  (d0),
            .i_req0_valid (v0),
            .i_req0_last  (l0),
            .o_req0_ready (rdy0[gi]),
            .i_req1_data  (d1),
            .i_req1_valid (v1),
            .i_req1_last  (l1),
            .o_req1_ready (rdy1[gi]),
            .o_wdata      (wdata_w[gi]),
            .o_wvalid     (wvalid[gi]),
            .i_wready     (wready),
            .o_grant      (grant_w[gi]),
            .o_busy       (busy[gi]),
            .o_err        (err_w[gi])
        );
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
        d0 = '0; d1 = '0; wready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        @(negedge clk);
        rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; wready = 1'b1; d0 = 8'hFF; d1 = 8'hEE;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                obs = {rdy0[k], rdy1[k], wvalid[k], busy[k], err_w[k], grant_w[k], wdata_w[k]};
                n_total++;
                if (obs !== 15'h0) $display("FAIL reset_outputs unit%0d cyc%0d: got %h want 0000", k, c, obs);
                else n_pass++;
            end
        end
        do_reset();
    endtask

    task automatic test_single_frame();
        logic [13:0] obs, exp;
        do_reset();
        wready = 1'b1; v0 = 1'b1; d0 = 8'hA0; l0 = 1'b0;
        #1;
        n_total++;
        if (busy[0] !== 1'b0) $display("FAIL sf_idle_busy: got %b want 0", busy[0]);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d0 = 8'hA0 + 8'(i); l0 = (i == 3);
            #1;
            obs = {busy[0], grant_w[0], wvalid[0], wdata_w[0], rdy0[0], rdy1[0]};
            exp = {1'b1, 2'b01, 1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0};
            n_total++;
            if (obs !== exp) $display("FAIL sf_beat%0d: got %h want %h", i, obs, exp);
            else n_pass++;
        end
        @(negedge clk);
        v0 = 1'b0; l0 = 1'b0;
        for (int j = 0; j < 12; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            obs = {busy[0], grant_w[0], wvalid[0], wdata_w[0], rdy0[0], rdy1[0]};
            exp = {1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
            n_total++;
            if (obs !== exp) $display("FAIL sf_gap%0d: got %h want %h", j, obs, exp);
            else n_pass++;
        end
        @(negedge clk);
        #1;
        n_total++;
        if (busy[0] !== 1'b0) $display("FAIL sf_gap_end: got busy %b want 0", busy[0]);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] seen [4];
        logic [1:0] prev;
        logic       p0, p1;
        int         n_seen;
        for (int i = 0; i < 4; i++) seen[i] = 2'b00;
        prev = 2'b00; p0 = 1'b0; p1 = 1'b0; n_seen = 0;
        do_reset();
        wready = 1'b1; v0 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 80 && n_seen < 4; k++) begin
            @(negedge clk);
            l0 = p0; l1 = p1; d0 = {7'h00, p0}; d1 = {7'h08, p1};
            #1;
            if (grant_w[0] !== 2'b00 && prev === 2'b00) begin
                seen[n_seen] = grant_w[0];
                n_seen++;
            end
            prev = grant_w[0];
            if (rdy0[0]) p0 = ~p0;
            if (rdy1[0]) p1 = ~p1;
        end
        n_total++;
        if (n_seen != 4) $display("FAIL rr_count: got %0d grants want 4", n_seen);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (seen[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL rr_grant%0d: got %b want %b", i, seen[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            else n_pass++;
        end
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] got [6];
        int         idx, ncyc, rdy_bad;
        idx = 0; ncyc = 0; rdy_bad = 0;
        for (int i = 0; i < 6; i++) got[i] = 8'h00;
        do_reset();
        v1 = 1'b1; d1 = 8'hB0; l1 = 1'b0; wready = 1'b0;
        #1;
        n_total++;
        if (busy[0] !== 1'b0) $display("FAIL bp_idle_busy: got %b want 0", busy[0]);
        else n_pass++;
        for (int k = 1; k <= 30 && idx < 6; k++) begin
            @(negedge clk);
            wready = k[0]; d1 = 8'hB0 + 8'(idx); l1 = (idx == 5);
            #1;
            if (rdy1[0] !== wready || grant_w[0] !== 2'b10) rdy_bad++;
            if (wvalid[0] && wready && rdy1[0]) begin
                got[idx] = wdata_w[0];
                idx++;
                if (idx == 6) ncyc = k;
            end
        end
        v1 = 1'b0; l1 = 1'b0;
        n_total++;
        if (idx != 6) $display("FAIL bp_beats: got %0d want 6", idx);
        else n_pass++;
        n_total++;
        if (ncyc != 11) $display("FAIL bp_cycles: got %0d want 11", ncyc);
        else n_pass++;
        n_total++;
        if (rdy_bad != 0) $display("FAIL bp_ready_follow: got %0d bad cycles want 0", rdy_bad);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (got[i] !== 8'hB0 + 8'(i)) $display("FAIL bp_data%0d: got %h want %h", i, got[i], 8'hB0 + 8'(i));
            else n_pass++;
        end
    endtask

    task automatic test_oversize();
        int         idx, n_out, n_drain, n_err, bad;
        logic       end_seen, got_after;
        logic [3:0] after;
        idx = 0; n_out = 0; n_drain = 0; n_err = 0; bad = 0;
        end_seen = 1'b0; got_after = 1'b0; after = 4'h0;
        do_reset();
        wready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            v1 = (idx < 10); d1 = 8'hC0 + 8'(idx); l1 = (idx == 9);
            #1;
            if (err_w[1]) n_err++;
            if (end_seen && !got_after) begin
                after = {busy[1], grant_w[1], wvalid[1]};
                got_after = 1'b1;
            end
            if (v1 && rdy1[1]) begin
                if (wvalid[1]) begin
                    if (wdata_w[1] !== 8'hC0 + 8'(idx)) bad++;
                    n_out++;
                end else begin
                    if (grant_w[1] !== 2'b10) bad++;
                    n_drain++;
                end
                idx++;
                if (idx == 10) end_seen = 1'b1;
            end
        end
        v1 = 1'b0; l1 = 1'b0;
        n_total++;
        if (n_out != 8) $display("FAIL ov_out_bytes: got %0d want 8", n_out);
        else n_pass++;
        n_total++;
        if (n_drain != 2) $display("FAIL ov_drained: got %0d want 2", n_drain);
        else n_pass++;
        n_total++;
        if (n_err != 1) $display("FAIL ov_err_pulses: got %0d want 1", n_err);
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL ov_data_grant: got %0d bad want 0", bad);
        else n_pass++;
        n_total++;
        if (after !== 4'b1000) $display("FAIL ov_gap_after_drain: got %b want 1000", after);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [14:0] obs;
        do_reset();
        wready = 1'b1; v0 = 1'b1; d0 = 8'hD0; l0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d0 = 8'hD0 + 8'(i);
        end
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            obs = {rdy0[0], rdy1[0], wvalid[0], busy[0], err_w[0], grant_w[0], wdata_w[0]};
            n_total++;
            if (obs !== 15'h0) $display("FAIL rm_outputs cyc%0d: got %h want 0000", c, obs);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1; d0 = 8'h5A; l0 = 1'b0;
        #1;
        n_total++;
        if ({busy[0], err_w[0]} !== 2'b00) $display("FAIL rm_restart_idle: got %b want 00", {busy[0], err_w[0]});
        else n_pass++;
        @(negedge clk);
        l0 = 1'b1;
        #1;
        n_total++;
        if ({grant_w[0], wvalid[0], wdata_w[0], rdy0[0]} !== {2'b01, 1'b1, 8'h5A, 1'b1})
            $display("FAIL rm_restart_grant: got %h want %h",
                     {grant_w[0], wvalid[0], wdata_w[0], rdy0[0]}, {2'b01, 1'b1, 8'h5A, 1'b1});
        else n_pass++;
        @(negedge clk);
        v0 = 1'b0; l0 = 1'b0;
        #1;
        n_total++;
        if ({busy[0], grant_w[0], err_w[0]} !== 4'b1000)
            $display("FAIL rm_restart_gap: got %b want 1000", {busy[0], grant_w[0], err_w[0]});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        wready = 1'b1; v0 = 1'b1; d0 = 8'hE0; l0 = 1'b0;
        #1;
        n_total++;
        if (busy[2] !== 1'b0) $display("FAIL b2b_idle: got %b want 0", busy[2]);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if ({grant_w[2], wdata_w[2]} !== {2'b01, 8'hE0}) $display("FAIL b2b_f1_b0: got %h want %h", {grant_w[2], wdata_w[2]}, {2'b01, 8'hE0});
        else n_pass++;
        @(negedge clk);
        d0 = 8'hE1; l0 = 1'b1;
        #1;
        n_total++;
        if ({grant_w[2], wdata_w[2], rdy0[2]} !== {2'b01, 8'hE1, 1'b1}) $display("FAIL b2b_f1_last: got %h want %h", {grant_w[2], wdata_w[2], rdy0[2]}, {2'b01, 8'hE1, 1'b1});
        else n_pass++;
        @(negedge clk);
        d0 = 8'hE2; l0 = 1'b0;
        #1;
        n_total++;
        if ({busy[2], grant_w[2], wvalid[2]} !== 4'b0000) $display("FAIL b2b_rearb: got %b want 0000", {busy[2], grant_w[2], wvalid[2]});
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if ({grant_w[2], wvalid[2], wdata_w[2]} !== {2'b01, 1'b1, 8'hE2}) $display("FAIL b2b_f2_b0: got %h want %h", {grant_w[2], wvalid[2], wdata_w[2]}, {2'b01, 1'b1, 8'hE2});
        else n_pass++;
        @(negedge clk);
        d0 = 8'hE3; l0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0; l0 = 1'b0;
        #1;
        n_total++;
        if (busy[2] !== 1'b0) $display("FAIL b2b_end_idle: got %b want 0", busy[2]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_oversize();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12: idle cycles enforced between frames.
REQ-002 SHALL have parameter MAX_LEN, default 1518: maximum bytes per frame before abort.
REQ-003 SHALL have parameter LEN_W, default 11: byte-counter width, with 2**LEN_W > MAX_LEN.
REQ-004 SHALL have port i_clk, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports i_req0_data / i_req1_data, input, 8: requester byte.
REQ-007 SHALL have ports i_req0_valid / i_req1_valid, input, 1: requester byte valid.
REQ-008 SHALL have ports i_req0_last / i_req1_last, input, 1: marks final byte of frame.
REQ-009 SHALL have ports o_req0_ready / o_req1_ready, output, 1: byte accepted from requester.
REQ-010 SHALL have port o_wdata, output, 8: byte to eth write channel.
REQ-011 SHALL have port o_wvalid, output, 1: o_wdata valid.
REQ-012 SHALL have port i_wready, input, 1: eth write channel ready.
REQ-013 SHALL have port o_grant, output, 2: one-hot current owner; 2'b00 when no owner.
REQ-014 SHALL have port o_busy, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port o_err, output, 1: one-cycle pulse on oversize-frame abort.

Function
REQ-016 SHALL implement states IDLE, BUSY, DRAIN, GAP.
REQ-017 Beat SHALL be defined as o_wvalid & i_wready in BUSY, or granted valid & ready in DRAIN.
REQ-018 In IDLE, a single valid requester SHALL be granted; the state enters BUSY on the next edge.
REQ-019 In IDLE, with both requesters valid, the grant SHALL go to the requester not granted last (round robin); after reset req0 wins first.
REQ-020 Arbitration SHALL occur only in IDLE; requests raised in BUSY/DRAIN/GAP wait.
REQ-021 In BUSY, o_wdata/o_wvalid SHALL combinationally follow the granted requester's data/valid, and granted ready SHALL equal i_wready (zero-cycle pass-through).
REQ-022 The ungranted requester's ready SHALL be 0 in all states; both readies SHALL be 0 in IDLE and GAP.
REQ-023 o_wdata SHALL be 8'h00 and o_wvalid 0 outside BUSY.
REQ-024 A granted requester dropping valid mid-frame SHALL hold BUSY with o_wvalid 0; there is no timeout.
REQ-025 The byte counter SHALL clear on grant and increment per beat.
REQ-026 A BUSY beat with last=1 SHALL move to GAP and record the owner as last-granted.
REQ-027 The MAX_LEN-th BUSY beat with last=0 SHALL pulse o_err and move to DRAIN.
REQ-028 If the MAX_LEN-th beat has last=1, the frame SHALL complete normally with no error.
REQ-029 In DRAIN, granted ready SHALL be 1 and o_wvalid 0; bytes are discarded until a beat with last=1, then GAP.
REQ-030 GAP SHALL last exactly IFG_CYCLES cycles, then IDLE; if IFG_CYCLES=0, BUSY/DRAIN SHALL go directly to IDLE.
REQ-031 o_grant SHALL hold the owner's one-hot value in BUSY and DRAIN, and 2'b00 otherwise.

Reset
REQ-032 Asserting i_rst_n low SHALL immediately force IDLE, counters 0, last-granted = req1 (so req0 wins first), and all outputs 0.
REQ-033 Reset mid-frame SHALL truncate the frame silently, with no o_err; a requester restart SHALL be arbitrated as a new frame.
REQ-034 Reset deassertion SHALL be synchronized externally; the block does not resynchronize it.

Structure
REQ-035 State encodings and default IFG_CYCLES/MAX_LEN constants SHALL live in shared package mhp_pkg.
REQ-036 The 2-way round-robin decision SHALL be sub-module rr_arb2 (inputs: two requests, last-granted; output: one-hot grant).
REQ-037 No storage of payload bytes SHALL exist; the datapath is a mux only.

Verification
REQ-038 Bench: req0 sends 4-byte frame, i_wready=1 -> 4 beats, then o_wvalid low 12 cycles, o_grant 2'b01 then 2'b00.
REQ-039 Bench: both valid continuously, 2-byte frames -> grants alternate 01,10,01,10; req0 first after reset.
REQ-040 Bench: i_wready toggles 1,0 during 6-byte frame -> 6 beats over 11 cycles, data order preserved, no duplicates.
REQ-041 Bench: MAX_LEN=8, req1 sends 10 bytes, last on 10th -> 8 bytes out, o_err pulse once, 2 bytes drained, then GAP.
REQ-042 Bench: i_rst_n low after 3rd beat -> all outputs 0 same cycle, no o_err, next frame granted cleanly.
REQ-043 Bench: IFG_CYCLES=0, back-to-back frames from req0 -> next grant one cycle after last beat.
